dfd_cla_transition_event_counter: RTL and testbench

Downstream consumer of the CLA debug-signal transition detector. It counts single-cycle transition-match pulses and qualifies them against a programmable occurrence threshold and an optional time window. On qualification it emits a one-cycle trigger pulse to the CLA action logic and a sticky `fired` status for CSR readback. It turns raw "from→to" transition hits into a counted, windowed trigger event.

---
 rtl/dfd_cla_pkg.sv | 14 +
 rtl/dfd_cla_window_timer.sv | 30 +++
 rtl/dfd_cla_transition_event_counter.sv | 127 ++++++++++++
 tb/tb_dfd_cla_transition_event_counter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dfd_cla_pkg.sv
// Shared types and CSR-facing default widths for the CLA transition event counter.
package dfd_cla_pkg;

  localparam int unsigned CLA_EVT_CNT_WIDTH = 16;
  localparam int unsigned CLA_EVT_WIN_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    COUNTING = 2'd2,
    FIRED    = 2'd3
  } cla_cnt_state_e;

endpackage

// File: rtl/dfd_cla_window_timer.sv
// Saturating window timer: counts cycles while enabled, flags the last cycle of a nonzero window.
module dfd_cla_window_timer
  import dfd_cla_pkg::*;
#(
  parameter int unsigned WIN_WIDTH = CLA_EVT_WIN_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [WIN_WIDTH-1:0] window,
  output logic                 expired
);

  localparam logic [WIN_WIDTH-1:0] WIN_ONE = WIN_WIDTH'(1);

  logic [WIN_WIDTH-1:0] r_timer;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      r_timer <= '0;
    end else if (enable && (r_timer != '1)) begin
      r_timer <= r_timer + WIN_ONE;
    end
  end

  // Expiry is seen during the cycle whose closing edge leaves COUNTING.
  assign expired = enable && (window != '0) && (r_timer == (window - WIN_ONE));

endmodule

// File: rtl/dfd_cla_transition_event_counter.sv
// Counts transition-match pulses, qualifies them against a threshold and optional window, and fires a trigger.
module dfd_cla_transition_event_counter
  import dfd_cla_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = CLA_EVT_CNT_WIDTH,
  parameter int unsigned WIN_WIDTH = CLA_EVT_WIN_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 match_in,
  input  logic                 arm,
  input  logic                 clear,
  input  logic                 auto_rearm,
  input  logic [CNT_WIDTH-1:0] threshold,
  input  logic [WIN_WIDTH-1:0] window,
  output logic                 trigger_out,
  output logic                 fired,
  output logic [CNT_WIDTH-1:0] count,
  output logic [1:0]           state
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  cla_cnt_state_e       r_state;
  cla_cnt_state_e       w_next_state;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] w_next_count;
  logic [CNT_WIDTH-1:0] w_thr_eff;
  logic [CNT_WIDTH-1:0] w_count_inc;
  logic                 r_trigger;
  logic                 r_fired;
  logic                 w_fire;
  logic                 w_expired;
  logic                 w_timer_clear;
  logic                 w_timer_enable;

  assign w_timer_enable = (r_state == COUNTING);
  assign w_timer_clear  = clear || arm || (r_state != COUNTING);

  dfd_cla_window_timer #(
    .WIN_WIDTH (WIN_WIDTH)
  ) u_window_timer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_timer_clear),
    .enable  (w_timer_enable),
    .window  (window),
    .expired (w_expired)
  );

  assign w_thr_eff   = (threshold == '0) ? CNT_ONE : threshold;
  assign w_count_inc = r_count + CNT_ONE;

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count;
    w_fire       = 1'b0;
    if (clear) begin
      w_next_state = IDLE;
      w_next_count = '0;
    end else if (arm) begin
      w_next_state = ARMED;
      w_next_count = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_next_count = '0;
        end
        ARMED: begin
          if (match_in) begin
            w_next_count = CNT_ONE;
            if (w_thr_eff == CNT_ONE) begin
              w_fire = 1'b1;
            end else begin
              w_next_state = COUNTING;
            end
          end
        end
        COUNTING: begin
          // >= so that a threshold lowered to or below count fires on the next match.
          if (match_in && (w_count_inc >= w_thr_eff)) begin
            w_fire       = 1'b1;
            w_next_count = w_count_inc;
          end else if (w_expired) begin
            w_next_state = ARMED;
            w_next_count = '0;
          end else if (match_in) begin
            w_next_count = w_count_inc;
          end
        end
        FIRED: begin
          if (auto_rearm) begin
            w_next_state = ARMED;
            w_next_count = '0;
          end
        end
      endcase
      if (w_fire) begin
        w_next_state = FIRED;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_trigger <= 1'b0;
      r_fired   <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_count   <= w_next_count;
      r_trigger <= w_fire;
      if (clear) begin
        r_fired <= 1'b0;
      end else if (w_fire) begin
        r_fired <= 1'b1;
      end
    end
  end

  assign trigger_out = r_trigger;
  assign fired       = r_fired;
  assign count       = r_count;
  assign state       = r_state;

endmodule

// File: tb/tb_dfd_cla_transition_event_counter.sv
// Directed scoreboard bench: each driven cycle queues its hand-computed post-edge outputs.
module tb_dfd_cla_transition_event_counter;
  import dfd_cla_pkg::*;

  localparam int CW = 16;
  localparam int WW = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          match_in = 1'b0;
  logic          arm = 1'b0;
  logic          clear = 1'b0;
  logic          auto_rearm = 1'b0;
  logic [CW-1:0] threshold = '0;
  logic [WW-1:0] window = '0;
  logic          trigger_out;
  logic          fired;
  logic [CW-1:0] count;
  logic [1:0]    state;

  dfd_cla_transition_event_counter #(
    .CNT_WIDTH (CW),
    .WIN_WIDTH (WW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .match_in    (match_in),
    .arm         (arm),
    .clear       (clear),
    .auto_rearm  (auto_rearm),
    .threshold   (threshold),
    .window      (window),
    .trigger_out (trigger_out),
    .fired       (fired),
    .count       (count),
    .state       (state)
  );

  always #5 clock = ~clock;

  typedef struct {
    int             due;
    string          name;
    cla_cnt_state_e st;
    logic [CW-1:0]  cnt;
    logic           trig;
    logic           fd;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: pops every expectation that has come due and compares against the DUT.
  always @(negedge clock) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      n_cmp++;
      if (mon_e.due != cyc || state !== mon_e.st || count !== mon_e.cnt ||
          trigger_out !== mon_e.trig || fired !== mon_e.fd) begin
        n_bad++;
        $display("FAIL %s @cyc %0d: got state=%0d count=%0d trig=%0b fired=%0b, want state=%0d count=%0d trig=%0b fired=%0b",
                 mon_e.name, cyc, state, count, trigger_out, fired,
                 mon_e.st, mon_e.cnt, mon_e.trig, mon_e.fd);
      end
    end
  end

  // Drives one cycle of inputs and queues the outputs expected after its closing edge.
  task automatic tick(input logic rn, input logic m, input logic a, input logic c,
                      input cla_cnt_state_e st, input int cnt, input logic tr,
                      input logic fd, input string nm);
    exp_t e;
    reset_n  = rn;
    match_in = m;
    arm      = a;
    clear    = c;
    e.due  = cyc + 1;
    e.name = nm;
    e.st   = st;
    e.cnt  = CW'(cnt);
    e.trig = tr;
    e.fd   = fd;
    sb.push_back(e);
    @(negedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);
    #1;
    threshold = 16'd3; window = '0; auto_rearm = 1'b0;
    tick(0, 0, 0, 0, IDLE, 0, 0, 0, "reset0");
    tick(0, 1, 0, 0, IDLE, 0, 0, 0, "reset1");
    tick(1, 1, 0, 0, IDLE, 0, 0, 0, "idle_ignore");

    // Test 1: threshold 3, no window, matches at 5, 9, 20.
    tick(1, 0, 1, 0, ARMED, 0, 0, 0, "t1_arm");
    for (int t = 1; t <= 22; t++) begin
      logic m;
      cla_cnt_state_e st;
      int c;
      m  = (t == 5 || t == 9 || t == 20);
      st = (t < 5) ? ARMED : (t < 20) ? COUNTING : FIRED;
      c  = (t >= 20) ? 3 : (t >= 9) ? 2 : (t >= 5) ? 1 : 0;
      tick(1, m, 0, 0, st, c, (t == 20), (t >= 20), "t1_seq");
    end

    // Test 2: threshold 2, window 4, matches at 0 and 6.
    tick(1, 0, 0, 1, IDLE, 0, 0, 0, "t2_clear");
    threshold = 16'd2; window = 16'd4;
    tick(1, 0, 1, 0, ARMED, 0, 0, 0, "t2_arm");
    tick(1, 1, 0, 0, COUNTING, 1, 0, 0, "t2_m0");
    tick(1, 0, 0, 0, COUNTING, 1, 0, 0, "t2_c1");
    tick(1, 0, 0, 0, COUNTING, 1, 0, 0, "t2_c2");
    tick(1, 0, 0, 0, COUNTING, 1, 0, 0, "t2_c3");
    tick(1, 0, 0, 0, ARMED, 0, 0, 0, "t2_expire");
    tick(1, 0, 0, 0, ARMED, 0, 0, 0, "t2_c5");
    tick(1, 1, 0, 0, COUNTING, 1, 0, 0, "t2_rematch");
    tick(1, 0, 0, 0, COUNTING, 1, 0, 0, "t2_c7");

    // Window of 1: second match must be on the very next cycle.
    threshold = 16'd2; window = 16'd1;
    tick(1, 0, 1, 0, ARMED, 0, 0, 0, "w1_arm");
    tick(1, 1, 0, 0, COUNTING, 1, 0, 0, "w1_m1");
    tick(1, 1, 0, 0, FIRED, 2, 1, 1, "w1_fire");
    tick(1, 0, 1, 0, ARMED, 0, 0, 1, "w1_rearm");
    tick(1, 1, 0, 0, COUNTING, 1, 0, 1, "w1_m1b");
    tick(1, 0, 0, 0, ARMED, 0, 0, 1, "w1_expire");

    // Expiry with a coincident match that does not reach threshold discards it.
    threshold = 16'd3; window = 16'd2;
    tick(1, 1, 0, 0, COUNTING, 1, 0, 1, "exp_m1");
    tick(1, 0, 0, 0, COUNTING, 1, 0, 1, "exp_wait");
    tick(1, 1, 0, 0, ARMED, 0, 0, 1, "exp_discard");
    tick(1, 0, 0, 0, ARMED, 0, 0, 1, "exp_after");

    // Test 4: third match lands on the expiry cycle; fire wins.
    tick(1, 0, 0, 1, IDLE, 0, 0, 0, "t4_clear");
    threshold = 16'd3; window = 16'd3;
    tick(1, 0, 1, 0, ARMED, 0, 0, 0, "t4_arm");
    tick(1, 1, 0, 0, COUNTING, 1, 0, 0, "t4_m1");
    tick(1, 1, 0, 0, COUNTING, 2, 0, 0, "t4_m2");
    tick(1, 0, 0, 0, COUNTING, 2, 0, 0, "t4_gap");
    tick(1, 1, 0, 0, FIRED, 3, 1, 1, "t4_fire_vs_expire");
    tick(1, 0, 0, 0, FIRED, 3, 0, 1, "t4_hold");

    // Test 5: clear beats arm; arm discards a coincident match.
    tick(1, 0, 1, 1, IDLE, 0, 0, 0, "t5_arm_clear");
    tick(1, 1, 1, 0, ARMED, 0, 0, 0, "t5_arm_match");
    threshold = 16'd3; window = '0;
    tick(1, 1, 0, 0, COUNTING, 1, 0, 0, "thr_m1");
    threshold = 16'd2;
    tick(1, 1, 0, 0, FIRED, 2, 1, 1, "thr_change");

    // Test 3: threshold 0 acts as 1, auto re-arm with match held high.
    tick(1, 0, 0, 1, IDLE, 0, 0, 0, "t3_clear");
    threshold = '0; auto_rearm = 1'b1;
    tick(1, 0, 1, 0, ARMED, 0, 0, 0, "t3_arm");
    for (int k = 0; k < 3; k++) begin
      tick(1, 1, 0, 0, FIRED, 1, 1, 1, "t3_fire");
      tick(1, 1, 0, 0, ARMED, 0, 0, 1, "t3_rearm");
    end
    auto_rearm = 1'b0;
    tick(1, 0, 0, 0, ARMED, 0, 0, 1, "t3_quiet");

    // Test 6: reset mid-count, then matches ignored until arm.
    threshold = 16'd10;
    tick(1, 0, 1, 0, ARMED, 0, 0, 1, "t6_arm_keeps_fired");
    for (int k = 1; k <= 5; k++) begin
      tick(1, 1, 0, 0, COUNTING, k, 0, 1, "t6_count");
    end
    tick(0, 1, 0, 0, IDLE, 0, 0, 0, "t6_reset");
    tick(1, 1, 0, 0, IDLE, 0, 0, 0, "t6_ignore1");
    tick(1, 1, 0, 0, IDLE, 0, 0, 0, "t6_ignore2");
    tick(1, 0, 1, 0, ARMED, 0, 0, 0, "t6_arm");
    tick(1, 1, 0, 0, COUNTING, 1, 0, 0, "t6_m1");
    tick(1, 0, 0, 0, COUNTING, 1, 0, 0, "t6_idle");

    for (int i = 0; i < 8 && sb.size() > 0; i++) @(negedge clock);
    #1;
    if (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
